// File: rtl/rib_xbar.sv
// Shared-bus crossbar: NUM_M masters onto NUM_S slaves through a locking owner
// register, with fixed-priority or round-robin arbitration and decode-error tracking.
module rib_xbar #(
  parameter int NUM_M  = 4,
  parameter int NUM_S  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ARB_RR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_req_i,
  input  logic [NUM_M-1:0]          m_we_i,
  input  logic [NUM_M*ADDR_W-1:0]   m_addr_i,
  input  logic [NUM_M*DATA_W-1:0]   m_data_i,
  output logic [DATA_W-1:0]         m_data_o,
  output logic [NUM_M-1:0]          m_gnt_o,
  output logic [ADDR_W-1:0]         s_addr_o,
  output logic [DATA_W-1:0]         s_data_o,
  output logic [NUM_S-1:0]          s_we_o,
  input  logic [NUM_S*DATA_W-1:0]   s_data_i,
  output logic                      hold_flag_o,
  output logic                      dec_err_o,
  output logic [7:0]                err_cnt_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {IDLE, OWNED} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rrPtr_q, rrPtr_d;
  logic          decErr_q, decErr_d;
  logic [7:0]    errCnt_q, errCnt_d;

  logic          pickValid;
  logic [IW-1:0] pickIdx;
  logic          ownValid;
  logic [ADDR_W-1:0] ownAddr;
  logic [3:0]    sel;
  logic          selOk;

  assign ownValid = (state_q == OWNED);
  assign ownAddr  = m_addr_i[owner_q*ADDR_W +: ADDR_W];
  assign sel      = ownAddr[ADDR_W-1 -: 4];
  assign selOk    = ({1'b0, sel} < 5'(NUM_S));

  // Round-robin scans requesters above the pointer first, then wraps to the rest.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    if (ARB_RR != 0) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (!pickValid && (i > int'(rrPtr_q)) && m_req_i[i]) begin
          pickValid = 1'b1;
          pickIdx   = IW'(i);
        end
      end
      for (int i = 0; i < NUM_M; i++) begin
        if (!pickValid && (i <= int'(rrPtr_q)) && m_req_i[i]) begin
          pickValid = 1'b1;
          pickIdx   = IW'(i);
        end
      end
    end else begin
      for (int i = NUM_M - 1; i >= 0; i--) begin
        if (m_req_i[i]) begin
          pickValid = 1'b1;
          pickIdx   = IW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rrPtr_q  <= IW'(NUM_M - 1);
      decErr_q <= 1'b0;
      errCnt_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rrPtr_q  <= rrPtr_d;
      decErr_q <= decErr_d;
      errCnt_q <= errCnt_d;
    end
  end

  // The owner keeps the bus while its request stays high; otherwise hand over directly.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rrPtr_d  = rrPtr_q;
    decErr_d = decErr_q;
    errCnt_d = errCnt_q;
    if (!(ownValid && m_req_i[owner_q])) begin
      state_d = pickValid ? OWNED : IDLE;
      if (pickValid) begin
        owner_d = pickIdx;
        rrPtr_d = pickIdx;
      end
    end
    if (ownValid && !selOk) begin
      decErr_d = 1'b1;
      if (errCnt_q != 8'hFF) begin
        errCnt_d = errCnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    m_gnt_o  = '0;
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = '0;
    m_data_o = '0;
    if (ownValid) begin
      m_gnt_o[owner_q] = 1'b1;
      s_addr_o = {4'b0000, ownAddr[ADDR_W-5:0]};
      s_data_o = m_data_i[owner_q*DATA_W +: DATA_W];
      for (int s = 0; s < NUM_S; s++) begin
        if (selOk && (int'(sel) == s)) begin
          s_we_o[s] = m_we_i[owner_q];
          m_data_o  = s_data_i[s*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign hold_flag_o = m_req_i[0] & ~m_gnt_o[0];
  assign dec_err_o   = decErr_q;
  assign err_cnt_o   = errCnt_q;

endmodule

// File: tb/tb_rib_xbar.sv
// Self-checking bench for rib_xbar: directed vectors, corner sequences and a
// randomized run against a behavioural model, on a fixed-priority and a round-robin instance.
module tb_rib_xbar;

  logic         clk;
  logic         rst;
  logic [3:0]   mReq;
  logic [3:0]   mWe;
  logic [127:0] mAddr;
  logic [127:0] mData;
  logic [255:0] sDataIn;

  logic [31:0]  mDataFp, sAddrFp, sDataFp, mDataRr, sAddrRr, sDataRr;
  logic [3:0]   gntFp, gntRr;
  logic [7:0]   sWeFp, sWeRr, errCntFp, errCntRr;
  logic         holdFp, holdRr, decErrFp, decErrRr;

  int compared   = 0;
  int mismatched = 0;

  rib_xbar #(.NUM_M(4), .NUM_S(8), .ADDR_W(32), .DATA_W(32), .ARB_RR(0)) dutFp (
    .clk(clk), .rst(rst), .m_req_i(mReq), .m_we_i(mWe), .m_addr_i(mAddr),
    .m_data_i(mData), .m_data_o(mDataFp), .m_gnt_o(gntFp), .s_addr_o(sAddrFp),
    .s_data_o(sDataFp), .s_we_o(sWeFp), .s_data_i(sDataIn), .hold_flag_o(holdFp),
    .dec_err_o(decErrFp), .err_cnt_o(errCntFp)
  );

  rib_xbar #(.NUM_M(4), .NUM_S(8), .ADDR_W(32), .DATA_W(32), .ARB_RR(1)) dutRr (
    .clk(clk), .rst(rst), .m_req_i(mReq), .m_we_i(mWe), .m_addr_i(mAddr),
    .m_data_i(mData), .m_data_o(mDataRr), .m_gnt_o(gntRr), .s_addr_o(sAddrRr),
    .s_data_o(sDataRr), .s_we_o(sWeRr), .s_data_i(sDataIn), .hold_flag_o(holdRr),
    .dec_err_o(decErrRr), .err_cnt_o(errCntRr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr1;
    logic [31:0] data1;
    logic [3:0]  expGnt;
    logic        expHold;
    logic [7:0]  expSWe;
    logic [31:0] expSAddr;
    logic [31:0] expMData;
    logic [31:0] expSData;
  } vec_t;

  vec_t vecs[14];

  // Model state per instance: index 0 = fixed priority, 1 = round robin.
  int   mOwner[2];
  int   mLast[2];
  int   mCnt[2];
  logic mDec[2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    mReq = v.req;
    mWe  = v.we;
    mAddr = '0;
    mData = '0;
    mAddr[32 +: 32] = v.addr1;
    mData[32 +: 32] = v.data1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst   = 1'b0;
    mReq  = '0;
    mWe   = '0;
    mAddr = '0;
    mData = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int pickNext(input int mode, input int last, input logic [3:0] req);
    if (mode == 0) begin
      for (int i = 0; i < 4; i++) if (req[i]) return i;
      return -1;
    end
    for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic checkAgainstModel();
    for (int d = 0; d < 2; d++) begin
      int          o;
      logic [31:0] a;
      int          sel;
      logic [3:0]  eGnt;
      logic [7:0]  eWe;
      logic [31:0] eAddr, eData, eMData;
      o = mOwner[d];
      eGnt = '0; eWe = '0; eAddr = '0; eData = '0; eMData = '0;
      if (o >= 0) begin
        a     = mAddr[o*32 +: 32];
        sel   = int'(a[31:28]);
        eGnt  = 4'(1 << o);
        eAddr = a & 32'h0FFF_FFFF;
        eData = mData[o*32 +: 32];
        if (sel < 8) begin
          eMData = sDataIn[sel*32 +: 32];
          if (mWe[o]) eWe = 8'(1 << sel);
        end
      end
      checkOutput(d == 0 ? "rndGntFp" : "rndGntRr", 32'(d == 0 ? gntFp : gntRr), 32'(eGnt));
      checkOutput(d == 0 ? "rndSWeFp" : "rndSWeRr", 32'(d == 0 ? sWeFp : sWeRr), 32'(eWe));
      checkOutput(d == 0 ? "rndSAddrFp" : "rndSAddrRr", d == 0 ? sAddrFp : sAddrRr, eAddr);
      checkOutput(d == 0 ? "rndSDataFp" : "rndSDataRr", d == 0 ? sDataFp : sDataRr, eData);
      checkOutput(d == 0 ? "rndMDataFp" : "rndMDataRr", d == 0 ? mDataFp : mDataRr, eMData);
      checkOutput(d == 0 ? "rndHoldFp" : "rndHoldRr", 32'(d == 0 ? holdFp : holdRr),
                  32'(mReq[0] & ~eGnt[0]));
      checkOutput(d == 0 ? "rndDecErrFp" : "rndDecErrRr", 32'(d == 0 ? decErrFp : decErrRr), 32'(mDec[d]));
      checkOutput(d == 0 ? "rndErrCntFp" : "rndErrCntRr", 32'(d == 0 ? errCntFp : errCntRr), 32'(mCnt[d]));
    end
  endtask

  task automatic modelEdge();
    for (int d = 0; d < 2; d++) begin
      if (mOwner[d] >= 0) begin
        logic [31:0] a;
        a = mAddr[mOwner[d]*32 +: 32];
        if (int'(a[31:28]) >= 8) begin
          mDec[d] = 1'b1;
          if (mCnt[d] < 255) mCnt[d]++;
        end
      end
      if (!(mOwner[d] >= 0 && mReq[mOwner[d]])) begin
        mOwner[d] = pickNext(d, mLast[d], mReq);
        if (mOwner[d] >= 0) mLast[d] = mOwner[d];
      end
    end
  endtask

  initial begin
    int   rrOrder[5];
    logic decodeBad;

    rst = 1'b0; mReq = 4'b0001; mWe = '0; mAddr = '0; mData = '0;
    for (int k = 0; k < 8; k++) sDataIn[k*32 +: 32] = 32'hD000_0000 + 32'(k);

    #1;
    checkOutput("rstGnt", 32'(gntFp), 32'h0);
    checkOutput("rstSWe", 32'(sWeFp), 32'h0);
    checkOutput("rstMData", mDataFp, 32'h0);
    checkOutput("rstHold", 32'(holdFp), 32'h1);
    checkOutput("rstDecErr", 32'(decErrFp), 32'h0);
    checkOutput("rstErrCnt", 32'(errCntFp), 32'h0);

    // Directed vectors: fixed priority, lock and handover, decode and readback.
    vecs[0]  = '{4'b0110, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{4'b0110, 4'b0000, 32'h0, 32'h0, 4'b0010, 1'b0, 8'h00, 32'h0, 32'hD000_0000, 32'h0};
    vecs[2]  = '{4'b0100, 4'b0000, 32'h0, 32'h0, 4'b0010, 1'b0, 8'h00, 32'h0, 32'hD000_0000, 32'h0};
    vecs[3]  = '{4'b0101, 4'b0000, 32'h0, 32'h0, 4'b0100, 1'b1, 8'h00, 32'h0, 32'hD000_0000, 32'h0};
    vecs[4]  = '{4'b0101, 4'b0000, 32'h0, 32'h0, 4'b0100, 1'b1, 8'h00, 32'h0, 32'hD000_0000, 32'h0};
    vecs[5]  = '{4'b0001, 4'b0000, 32'h0, 32'h0, 4'b0100, 1'b1, 8'h00, 32'h0, 32'hD000_0000, 32'h0};
    vecs[6]  = '{4'b0001, 4'b0000, 32'h0, 32'h0, 4'b0001, 1'b0, 8'h00, 32'h0, 32'hD000_0000, 32'h0};
    vecs[7]  = '{4'b0000, 4'b0000, 32'h0, 32'h0, 4'b0001, 1'b0, 8'h00, 32'h0, 32'hD000_0000, 32'h0};
    vecs[8]  = '{4'b0000, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{4'b0010, 4'b0010, 32'h3000_0010, 32'hA5A5_A5A5, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{4'b0010, 4'b0010, 32'h3000_0010, 32'hA5A5_A5A5, 4'b0010, 1'b0, 8'b0000_1000,
                 32'h0000_0010, 32'hD000_0003, 32'hA5A5_A5A5};
    vecs[11] = '{4'b0010, 4'b0000, 32'h2000_0004, 32'hA5A5_A5A5, 4'b0010, 1'b0, 8'h00,
                 32'h0000_0004, 32'hD000_0002, 32'hA5A5_A5A5};
    vecs[12] = '{4'b0000, 4'b0000, 32'h0, 32'h0, 4'b0010, 1'b0, 8'h00, 32'h0, 32'hD000_0000, 32'h0};
    vecs[13] = '{4'b0000, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0};

    doReset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0dGnt", i), 32'(gntFp), 32'(vecs[i].expGnt));
      checkOutput($sformatf("vec%0dHold", i), 32'(holdFp), 32'(vecs[i].expHold));
      checkOutput($sformatf("vec%0dSWe", i), 32'(sWeFp), 32'(vecs[i].expSWe));
      checkOutput($sformatf("vec%0dSAddr", i), sAddrFp, vecs[i].expSAddr);
      checkOutput($sformatf("vec%0dMData", i), mDataFp, vecs[i].expMData);
      checkOutput($sformatf("vec%0dSData", i), sDataFp, vecs[i].expSData);
    end

    // Round robin: all request, each owner releases after one cycle.
    rrOrder = '{0, 1, 2, 3, 0};
    doReset();
    @(negedge clk);
    mReq = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("rrOrder%0d", n), 32'(gntRr), 32'(1 << rrOrder[n]));
      mReq = 4'b1111 & ~4'(1 << rrOrder[n]);
    end

    // Sustained out-of-range accesses saturate the error counter.
    doReset();
    @(negedge clk);
    mReq = 4'b0001;
    mWe  = 4'b0001;
    mAddr[31:0] = 32'hF000_0000;
    mData[31:0] = 32'h1234_5678;
    decodeBad = 1'b0;
    for (int n = 0; n < 310; n++) begin
      @(negedge clk);
      #1;
      if (sWeFp != 0 || sWeRr != 0 || mDataFp != 0 || mDataRr != 0) decodeBad = 1'b1;
    end
    checkOutput("decNoWriteNoData", 32'(decodeBad), 32'h0);
    checkOutput("decErrFp", 32'(decErrFp), 32'h1);
    checkOutput("decCntFp", 32'(errCntFp), 32'hFF);
    checkOutput("decErrRr", 32'(decErrRr), 32'h1);
    checkOutput("decCntRr", 32'(errCntRr), 32'hFF);

    // Reset pulsed while master 3 holds the bus.
    doReset();
    @(negedge clk);
    mReq = 4'b1000;
    mAddr[96 +: 32] = 32'hF000_0000;
    @(negedge clk);
    #1;
    checkOutput("lockGnt", 32'(gntFp), 32'b1000);
    @(negedge clk);
    mReq = 4'b1001;
    rst  = 1'b0;
    #1;
    checkOutput("midRstGntFp", 32'(gntFp), 32'h0);
    checkOutput("midRstGntRr", 32'(gntRr), 32'h0);
    checkOutput("midRstHold", 32'(holdFp), 32'h1);
    checkOutput("midRstErrCnt", 32'(errCntFp), 32'h0);
    checkOutput("midRstDecErr", 32'(decErrFp), 32'h0);
    @(negedge clk);
    mReq = 4'b1000;
    rst  = 1'b1;
    #1;
    checkOutput("relGntBeforeEdge", 32'(gntFp), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("relGntFp", 32'(gntFp), 32'b1000);
    checkOutput("relGntRr", 32'(gntRr), 32'b1000);

    // Randomized traffic against the behavioural model.
    doReset();
    for (int d = 0; d < 2; d++) begin
      mOwner[d] = -1;
      mLast[d]  = 3;
      mCnt[d]   = 0;
      mDec[d]   = 1'b0;
    end
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) mReq[i] = ~mReq[i];
        mWe[i] = 1'($urandom);
        mAddr[i*32 +: 32] = {4'($urandom_range(0, 11)), 28'($urandom)};
        mData[i*32 +: 32] = $urandom;
      end
      for (int k = 0; k < 8; k++) sDataIn[k*32 +: 32] = $urandom;
      #1;
      checkAgainstModel();
      modelEdge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
